// File: rtl/ram_burst_reader.sv
// Burst read initiator for one RAM port: issues sequential reads,
// absorbs the one-cycle read latency and streams words via valid/ready.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write_enable,
  output logic [DATA_WIDTH-1:0] ram_in,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            fcnt_q, fcnt_d;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  room;
  logic [2:0]            occ;

  assign ram_write_enable = 1'b0;
  assign ram_in           = '0;
  assign ram_addr         = addr_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign out_valid        = (fcnt_q != 2'd0);
  assign out_data         = mem_q[rd_q];

  assign push = inflight_q;
  assign pop  = out_valid & out_ready;

  // A pop this cycle frees a slot, so it counts as credit now.
  assign occ  = {1'b0, fcnt_q} + {2'b00, inflight_q};
  assign room = occ < (3'd2 + {2'b00, pop});

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (push) begin
      mem_d[wr_q] = ram_out;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d = length;
          cnt_d = '0;
          if (length == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = base_addr;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue = room;
        if (issue) begin
          cnt_d = cnt_q + 1'b1;
          // Keep the last issued address once the count is reached.
          if (cnt_d == len_q) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && fcnt_d == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      fcnt_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && !pop && fcnt_q == 2'd2));
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-read RAM model.
module tb_ram_burst_reader;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_write_enable;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] got_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_write_enable(ram_write_enable),
    .ram_in(ram_in),
    .ram_out(ram_out),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ram_out <= mem[ram_addr];

  function automatic logic [7:0] exp_word(input int a);
    logic [15:0] x;
    x = 16'(a) + 16'h0010;
    return x[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [15:0] b, input logic [16:0] l);
    @(negedge clock);
    start = 1'b1;
    base_addr = b;
    length = l;
    @(negedge clock);
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: low 10 cycles then random; 2: ready high + stray start
  task automatic collect(input logic [15:0] b, input int n, input int mode);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    logic rdy;
    got_q.delete();
    chk("first_addr", 32'(ram_addr), 32'(b));
    while (got < n && cyc < 4 * n + 64) begin
      rdy = 1'b1;
      if (mode == 1) rdy = (cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      if (mode == 2 && cyc == 3) begin
        start = 1'b1;
        base_addr = 16'h0080;
        length = 17'd2;
      end else begin
        start = 1'b0;
      end
      if (mode != 1 && cyc < 3)
        chk("latency", 32'(out_valid), 32'(cyc == 2));
      if (mode == 0 && cyc < 4 && cyc < n)
        chk("addr_seq", 32'(ram_addr), 32'(16'(b + 16'(cyc))));
      if (mode != 1 && got > 0)
        chk("no_bubble", 32'(out_valid), 32'd1);
      if (mode == 1 && cyc == 9)
        chk("bp_addr_hold", 32'(ram_addr), 32'(b) + 32'd2);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(held));
      end
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk($sformatf("word%0d", got), 32'(out_data), 32'(exp_word(b + got)));
        got_q.push_back(out_data);
        got++;
      end
      stalled = out_valid && !rdy;
      held = out_data;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("word_count", 32'(got), 32'(n));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_no_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = exp_word(i);

    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("we_low", 32'(ram_write_enable), 32'd0);
    chk("ram_in_zero", 32'(ram_in), 32'd0);
    reset = 1'b0;

    start_burst(16'h0004, 17'd4);
    collect(16'h0004, 4, 0);
    chk("t1_w0", 32'(got_q[0]), 32'h14);
    chk("t1_w1", 32'(got_q[1]), 32'h15);
    chk("t1_w2", 32'(got_q[2]), 32'h16);
    chk("t1_w3", 32'(got_q[3]), 32'h17);

    start_burst(16'hFFFE, 17'd4);
    collect(16'hFFFE, 4, 0);
    chk("wrap_w0", 32'(got_q[0]), 32'h0E);
    chk("wrap_w1", 32'(got_q[1]), 32'h0F);
    chk("wrap_w2", 32'(got_q[2]), 32'h10);
    chk("wrap_w3", 32'(got_q[3]), 32'h11);

    start_burst(16'h0010, 17'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("len0_done_clr", 32'(done), 32'd0);
    chk("len0_busy_clr", 32'(busy), 32'd0);
    chk("len0_valid2", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("len0_valid3", 32'(out_valid), 32'd0);

    start_burst(16'h0100, 17'd8);
    collect(16'h0100, 8, 1);

    start_burst(16'h0040, 17'd6);
    collect(16'h0040, 6, 2);
    @(negedge clock);
    chk("stray_start_idle", 32'(busy), 32'd0);

    out_ready = 1'b1;
    start_burst(16'h0030, 17'd6);
    repeat (2) @(negedge clock);
    chk("rb_w0", 32'(out_data), 32'h40);
    @(negedge clock);
    chk("rb_w1", 32'(out_data), 32'h41);
    @(negedge clock);
    chk("rb_w2", 32'(out_data), 32'h42);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    repeat (2) @(negedge clock);
    chk("held_rst_valid", 32'(out_valid), 32'd0);
    chk("held_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_done", 32'(done), 32'd0);

    start_burst(16'h0020, 17'd2);
    collect(16'h0020, 2, 0);
    chk("pr_w0", 32'(got_q[0]), 32'h30);
    chk("pr_w1", 32'(got_q[1]), 32'h31);

    start_burst(16'h0000, 17'h10000);
    collect(16'h0000, 65536, 0);
    chk("long_last", 32'(got_q[65535]), 32'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
